// File: rtl/riscv_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifu_entry_t    : one buffered instruction (fetch PC + instruction word)
//   ifu_state_e    : fetch FSM state (IFU_IDLE, IFU_RUN)
//   IFU_RESET_ADDR : default first fetch address after reset
package riscv_ifu_pkg;

  localparam logic [31:0] IFU_RESET_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ifu_entry_t;

  typedef enum logic {
    IFU_IDLE = 1'b0,
    IFU_RUN  = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/riscv_ifu_if.sv
// Bus bundle for the fetch unit: instruction memory request/response channel
// and the IFU->IDU instruction channel.
//   master : the fetch unit (drives imem requests and the IDU instruction channel)
//   slave  : the environment (memory + decode stage)
interface riscv_ifu_if;

  logic        imem_req_vld;
  logic        imem_req_rdy;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic        ifu_vld;
  logic        ifu_rdy;
  logic [31:0] ifu_addr;
  logic [31:0] ifu_data;

  modport master (
    output imem_req_vld, imem_req_addr, ifu_vld, ifu_addr, ifu_data,
    input  imem_req_rdy, imem_rsp_vld, imem_rsp_data, ifu_rdy
  );

  modport slave (
    input  imem_req_vld, imem_req_addr, ifu_vld, ifu_addr, ifu_data,
    output imem_req_rdy, imem_rsp_vld, imem_rsp_data, ifu_rdy
  );

endinterface

// File: rtl/riscv_ifu_fifo.sv
// Synchronous instruction buffer of ifu_entry_t.
//   clock, reset : clock, asynchronous active-low reset
//   push/push_data : write an entry (ignored when full unless popping the same cycle)
//   pop          : remove the head entry (ignored when empty)
//   flush        : empty the buffer; wins over push
//   head         : current head entry (storage is reset, so never X)
//   count/full/empty : occupancy status
module riscv_ifu_fifo
  import riscv_ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  ifu_entry_t                   push_data,
  input  logic                         pop,
  input  logic                         flush,
  output ifu_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  ifu_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: keeps the fetch PC, issues in-order word fetches,
// buffers responses and presents them to the decode stage.
//   clock, reset  : clock, asynchronous active-low reset
//   fetch_en      : allow issuing new fetch requests
//   redirect_vld  : one-cycle pulse restarting fetch at redirect_addr (low 2 bits ignored)
//   redirect_addr : new fetch PC
//   bus (master)  : imem request/response channel and IFU->IDU instruction channel
module riscv_ifu
  import riscv_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = IFU_RESET_ADDR,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_addr,
  riscv_ifu_if.master bus
);

  localparam int unsigned   CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_LIM  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] OUTST_LIM  = CW'(MAX_OUTST);
  localparam logic [31:0]   ALIGN_MASK = 32'hFFFF_FFFC;

  ifu_state_e    state_q;
  ifu_state_e    state_d;
  logic [31:0]   pc_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] drop_q;

  logic          req_vld;
  logic          req_hs;
  logic          rsp_keep;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  ifu_entry_t    fifo_head;
  ifu_entry_t    fifo_wdata;
  logic [31:0]   redirect_pc;

  assign redirect_pc = redirect_addr & ALIGN_MASK;

  // Next state plus request issue. A request is only issued when every
  // outstanding response is guaranteed a buffer slot.
  always_comb begin
    state_d = state_q;
    req_vld = 1'b0;
    unique case (state_q)
      IFU_IDLE: if (fetch_en)  state_d = IFU_RUN;
      IFU_RUN: begin
        if (!fetch_en) state_d = IFU_IDLE;
        req_vld = ~redirect_vld
                & (({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_LIM)
                & (inflight_q < OUTST_LIM);
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  assign req_hs = req_vld & bus.imem_req_rdy;

  always_comb begin
    inflight_nxt = inflight_q;
    if (req_hs && !bus.imem_rsp_vld)      inflight_nxt = inflight_q + CW'(1);
    else if (!req_hs && bus.imem_rsp_vld) inflight_nxt = inflight_q - CW'(1);
  end

  // A response arriving with a redirect belongs to the old stream and is dropped.
  assign rsp_keep   = bus.imem_rsp_vld & (drop_q == '0) & ~redirect_vld;
  assign fifo_pop   = bus.ifu_vld & bus.ifu_rdy;
  // The credit rule already reserves a slot; the full term only keeps the
  // buffer and addr_q consistent should that ever be violated.
  assign fifo_push  = rsp_keep & (~fifo_full | fifo_pop);
  assign fifo_wdata = '{addr: addr_q, data: bus.imem_rsp_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IFU_IDLE;
      pc_q       <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_nxt;
      if (redirect_vld) begin
        pc_q   <= redirect_pc;
        addr_q <= redirect_pc;
        // Everything still outstanding after this cycle is stale; this
        // already includes whatever remained of an earlier drop count.
        drop_q <= inflight_nxt;
      end else begin
        if (req_hs)    pc_q   <= pc_q + 32'd4;
        if (fifo_push) addr_q <= addr_q + 32'd4;
        if (bus.imem_rsp_vld && drop_q != '0) drop_q <= drop_q - CW'(1);
      end
    end
  end

  riscv_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (redirect_vld),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.imem_req_vld  = req_vld;
  assign bus.imem_req_addr = pc_q;
  assign bus.ifu_vld       = ~fifo_empty;
  assign bus.ifu_addr      = fifo_head.addr;
  assign bus.ifu_data      = fifo_head.data;

endmodule
